// File: rtl/seq_chunk_comparator.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands CHUNK bits per
// clock, MSB chunk first, stopping at the first differing chunk.
module seq_chunk_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_comparator: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_COMPARE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_d, done_d, lt_d, gt_d, eq_d;

  int unsigned       shamt;
  logic [CHUNK-1:0]  ca, cb;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      lt      <= lt_d;
      gt      <= gt_d;
      eq      <= eq_d;
    end
  end

  // Next-state, chunk selection and result logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    busy_d  = busy;
    done_d  = 1'b0;
    lt_d    = lt;
    gt_d    = gt;
    eq_d    = eq;

    shamt = (NCHUNK - 1 - 32'(idx_q)) * CHUNK;
    ca    = CHUNK'(a_q >> shamt);
    cb    = CHUNK'(b_q >> shamt);
    // Flipping the sign bit maps two's-complement order onto unsigned order
    if (sgn_q && idx_q == '0) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = signed_mode;
          idx_d   = '0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (ca != cb) begin
          lt_d    = (ca < cb);
          gt_d    = (ca > cb);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (idx_q == IDXW'(NCHUNK - 1)) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Self-checking bench for seq_chunk_comparator: directed handshake/reset steps on a
// 16/4 instance plus a randomized sweep over 16/16, 16/1 and 17/1 instances.
module tb_seq_chunk_comparator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, WIDTH=16 CHUNK=4
  logic        st_m, sm_m;
  logic [15:0] a_m, b_m;
  logic        busy_m, done_m;
  logic [2:0]  r_m;  // {lt, gt, eq}

  seq_chunk_comparator #(.WIDTH(16), .CHUNK(4)) u_main (
    .clk(clk), .rst_n(rst_n), .start(st_m), .A(a_m), .B(b_m), .signed_mode(sm_m),
    .busy(busy_m), .done(done_m), .lt(r_m[2]), .gt(r_m[1]), .eq(r_m[0])
  );

  // Sweep instances: 0 = 16/16, 1 = 16/1, 2 = 17/1
  logic             st_sw;
  logic [2:0]       sm_s;
  logic [2:0][16:0] a_s, b_s;
  logic [2:0]       busy_s, done_s;
  logic [2:0][2:0]  r_s;
  int sw_w [3] = '{16, 16, 17};
  int sw_c [3] = '{16, 1, 1};

  seq_chunk_comparator #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(st_sw), .A(a_s[0][15:0]), .B(b_s[0][15:0]),
    .signed_mode(sm_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .lt(r_s[0][2]), .gt(r_s[0][1]), .eq(r_s[0][0])
  );
  seq_chunk_comparator #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(st_sw), .A(a_s[1][15:0]), .B(b_s[1][15:0]),
    .signed_mode(sm_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .lt(r_s[1][2]), .gt(r_s[1][1]), .eq(r_s[1][0])
  );
  seq_chunk_comparator #(.WIDTH(17), .CHUNK(1)) u_w17 (
    .clk(clk), .rst_n(rst_n), .start(st_sw), .A(a_s[2]), .B(b_s[2]),
    .signed_mode(sm_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .lt(r_s[2][2]), .gt(r_s[2][1]), .eq(r_s[2][0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer ordering of the operand values, latency from first differing chunk
  function automatic void ref_cmp(input logic [31:0] a, input logic [31:0] b, input int w,
                                  input int c, input bit s, output logic [2:0] res,
                                  output int j);
    longint va, vb, mask, sh;
    bit found;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    res = (va < vb) ? 3'b100 : ((va > vb) ? 3'b010 : 3'b001);
    mask = (longint'(1) << c) - 1;
    j = w / c;
    found = 1'b0;
    for (int k = 0; k < w / c; k++) begin
      sh = longint'(w - (k + 1) * c);
      if (!found && (((longint'(a) >> sh) & mask) != ((longint'(b) >> sh) & mask))) begin
        j = k + 1;
        found = 1'b1;
      end
    end
  endfunction

  // One operation on the main instance; disturb: 1 = start pulse + new operands, 2 = new operands only
  task automatic op_main(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [2:0] exp_r, input int exp_j, input int disturb,
                         input string tag);
    bit got;
    got = 1'b0;
    @(negedge clk); a_m = a; b_m = b; sm_m = s; st_m = 1'b1;
    @(posedge clk);
    @(negedge clk); st_m = 1'b0;
    chk({tag, " busy_after_accept"}, 32'(busy_m), 1);
    chk({tag, " cleared"}, 32'({done_m, r_m}), 0);
    for (int n = 1; n <= 24 && !got; n++) begin
      @(negedge clk);
      if (done_m) begin
        got = 1'b1;
        chk({tag, " latency"}, n, exp_j);
        chk({tag, " result"}, 32'(r_m), 32'(exp_r));
        chk({tag, " busy_at_done"}, 32'(busy_m), 0);
      end else if (n == 1 && disturb != 0) begin
        a_m = 16'h0000; b_m = 16'hFFFF; sm_m = ~s; st_m = (disturb == 1);
      end else begin
        st_m = 1'b0;
      end
    end
    chk({tag, " done_seen"}, 32'(got), 1);
    if (got) begin
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(done_m), 0);
      chk({tag, " result_held"}, 32'(r_m), 32'(exp_r));
    end
  endtask

  initial begin
    logic [16:0] ra, rb, msk;
    logic [2:0]  er [3];
    int          ej [3];
    logic [2:0]  got;
    logic [2:0]  mr;
    int          mj;

    rst_n = 1'b0;
    st_m = 1'b0; sm_m = 1'b0; a_m = '0; b_m = '0;
    st_sw = 1'b0; sm_s = '0; a_s = '0; b_s = '0;

    // Reset with inputs toggling
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("reset main n%0d", n), 32'({busy_m, done_m, r_m}), 0);
      chk($sformatf("reset sweep n%0d", n), 32'({busy_s, done_s, r_s}), 0);
      st_m = 1'($urandom); sm_m = 1'($urandom); a_m = 16'($urandom); b_m = 16'($urandom);
      st_sw = 1'($urandom); sm_s = 3'($urandom); a_s[2] = 17'($urandom);
    end
    @(negedge clk);
    st_m = 1'b0; st_sw = 1'b0;
    rst_n = 1'b1;

    op_main(16'h0000, 16'h0000, 1'b0, 3'b001, 4, 0, "zero_eq");
    op_main(16'd11, 16'd10, 1'b0, 3'b010, 4, 0, "last_gt");
    op_main(16'd8, 16'd11, 1'b0, 3'b100, 4, 0, "last_lt");
    op_main(16'd11, 16'd11, 1'b0, 3'b001, 4, 0, "last_eq");
    op_main(16'h8000, 16'h0001, 1'b0, 3'b010, 1, 0, "early_unsigned_gt");
    op_main(16'h8000, 16'h0001, 1'b1, 3'b100, 1, 0, "early_signed_lt");
    op_main(16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4, 0, "signed_neg_gt");
    op_main(16'd11, 16'd10, 1'b0, 3'b010, 4, 1, "start_while_busy");
    op_main(16'd8, 16'd11, 1'b0, 3'b100, 4, 2, "operand_change");

    // Start held through done: second op accepted on the edge after done
    @(negedge clk); a_m = 16'd8; b_m = 16'd11; sm_m = 1'b0; st_m = 1'b1;
    @(posedge clk);
    @(negedge clk); a_m = 16'd11; b_m = 16'd11;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk($sformatf("b2b done n%0d", n), 32'(done_m), 32'(n == 4 || n == 9));
      if (n == 4) chk("b2b first_result", 32'(r_m), 32'(3'b100));
      if (n == 5) begin
        chk("b2b second_accept_busy", 32'(busy_m), 1);
        chk("b2b second_accept_cleared", 32'(r_m), 0);
        st_m = 1'b0;
      end
      if (n == 9) chk("b2b second_result", 32'(r_m), 32'(3'b001));
    end

    // Reset during the second COMPARE cycle
    @(negedge clk); a_m = 16'h1234; b_m = 16'h1235; sm_m = 1'b0; st_m = 1'b1;
    @(posedge clk);
    @(negedge clk); st_m = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_mid async_clear", 32'({busy_m, done_m, r_m}), 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("rst_mid held n%0d", n), 32'({busy_m, done_m, r_m}), 0);
      if (n == 2) rst_n = 1'b1;
    end
    op_main(16'h1234, 16'h1235, 1'b0, 3'b100, 4, 0, "rst_mid_after");

    // Random operations on the main instance
    for (int it = 0; it < 100; it++) begin
      ra = 17'($urandom) & 17'h0FFFF;
      rb = ($urandom_range(0, 1) == 0) ? (ra ^ (17'(1) << $urandom_range(0, 15)))
                                       : (17'($urandom) & 17'h0FFFF);
      sm_m = 1'($urandom);
      ref_cmp(32'(ra), 32'(rb), 16, 4, sm_m, mr, mj);
      op_main(ra[15:0], rb[15:0], sm_m, mr, mj, 0, $sformatf("main_rand%0d", it));
    end

    // Parameter sweep, three configurations in lockstep
    for (int it = 0; it < 1000; it++) begin
      for (int i = 0; i < 3; i++) begin
        msk = (sw_w[i] == 17) ? 17'h1FFFF : 17'h0FFFF;
        ra = 17'($urandom) & msk;
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (17'(1) << $urandom_range(0, sw_w[i] - 1));
          default: rb = 17'($urandom) & msk;
        endcase
        a_s[i] = ra;
        b_s[i] = rb;
        sm_s[i] = 1'($urandom);
        ref_cmp(32'(ra), 32'(rb), sw_w[i], sw_c[i], sm_s[i], er[i], ej[i]);
      end
      @(negedge clk); st_sw = 1'b1;
      @(posedge clk);
      @(negedge clk); st_sw = 1'b0;
      got = '0;
      for (int n = 1; n <= 24 && got != 3'b111; n++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (done_s[i] && !got[i]) begin
            got[i] = 1'b1;
            chk($sformatf("sweep%0d it%0d latency", i, it), n, ej[i]);
            chk($sformatf("sweep%0d it%0d result", i, it), 32'(r_s[i]), 32'(er[i]));
          end
        end
      end
      for (int i = 0; i < 3; i++)
        chk($sformatf("sweep%0d it%0d done_seen", i, it), 32'(got[i]), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
